// File: rtl/hex2bin_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
// FSM encoding, BCD digit width and the power-of-ten constant function.
package hex2bin_pkg;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_SUBT = 1'b1
    } state_t;

    localparam int BCD_W = 4;

    // Elaboration-time helper; only ever called with constant arguments.
    function automatic logic [63:0] pow10(input int n);
        logic [63:0] v;
        v = 64'd1;
        for (int i = 0; i < n; i++) begin
            v = v * 64'd10;
        end
        return v;
    endfunction

endpackage

// File: rtl/bin2bcd_digit_sub.sv
// Combinational compare/subtract step: ge = rem >= k, diff = rem - k.
// diff is only meaningful when ge is high; the caller never uses it otherwise.
module bin2bcd_digit_sub #(
    parameter int W = 8
) (
    input  logic [W-1:0] i_rem,
    input  logic [W-1:0] i_k,
    output logic         o_ge,
    output logic [W-1:0] o_diff
);

    assign o_ge   = (i_rem >= i_k);
    assign o_diff = i_rem - i_k;

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter, one compare/subtract per clock, MSD first.
// Define BIN2BCD_BLANK_EN to enable the registered leading-zero blank mask.
module bin2bcd_seq
    import hex2bin_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input  logic                    i_clk,
    input  logic                    i_clr,
    input  logic                    i_start,
    input  logic [WIDTH-1:0]        i_din,
    output logic                    o_busy,
    output logic                    o_done,
    output logic [BCD_W*DIGITS-1:0] o_bcd,
    output logic [DIGITS-1:0]       o_blank,
    output state_t                  o_dbg_state
);

    // Handshake: i_start is a request sampled only while idle (o_busy=0);
    // o_done is a one-cycle completion strobe, o_bcd/o_blank stay valid after it.

    // Wide enough to hold pow10(DIGITS-1) as well as any input value.
    localparam int CW = WIDTH + BCD_W * DIGITS;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    if (pow10(DIGITS) <= ((64'd1 << WIDTH) - 64'd1)) begin : g_digits_check
        $error("bin2bcd_seq: DIGITS=%0d too small for WIDTH=%0d", DIGITS, WIDTH);
    end

    state_t                    r_state;
    logic [CW-1:0]             r_rem;
    logic [BCD_W-1:0]          r_cnt;
    logic [IW-1:0]             r_idx;
    logic                      r_busy;
    logic                      r_done;
    logic [BCD_W*DIGITS-1:0]   r_bcd;

    state_t                    w_state_next;
    logic [CW-1:0]             w_rem_next;
    logic [BCD_W-1:0]          w_cnt_next;
    logic [IW-1:0]             w_idx_next;
    logic                      w_busy_next;
    logic                      w_done_next;
    logic [BCD_W*DIGITS-1:0]   w_bcd_next;

    logic [CW-1:0]             w_k;
    logic                      w_ge;
    logic [CW-1:0]             w_diff;

    always_comb begin
        w_k = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (r_idx == IW'(i)) begin
                w_k = CW'(pow10(i));
            end
        end
    end

    bin2bcd_digit_sub #(
        .W (CW)
    ) u_digit_sub (
        .i_rem  (r_rem),
        .i_k    (w_k),
        .o_ge   (w_ge),
        .o_diff (w_diff)
    );

    always_comb begin
        w_state_next = r_state;
        w_rem_next   = r_rem;
        w_cnt_next   = r_cnt;
        w_idx_next   = r_idx;
        w_busy_next  = r_busy;
        w_done_next  = 1'b0;
        w_bcd_next   = r_bcd;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_state_next = S_SUBT;
                    w_rem_next   = CW'(i_din);
                    w_idx_next   = IW'(DIGITS - 1);
                    w_cnt_next   = '0;
                    w_busy_next  = 1'b1;
                    w_bcd_next   = '0;
                end
            end
            S_SUBT: begin
                if (w_ge) begin
                    w_rem_next = w_diff;
                    w_cnt_next = r_cnt + 4'd1;
                end else begin
                    for (int i = 0; i < DIGITS; i++) begin
                        if (r_idx == IW'(i)) begin
                            w_bcd_next[BCD_W*i +: BCD_W] = r_cnt;
                        end
                    end
                    w_cnt_next = '0;
                    if (r_idx != '0) begin
                        w_idx_next = r_idx - 1'b1;
                    end else begin
                        w_state_next = S_IDLE;
                        w_busy_next  = 1'b0;
                        w_done_next  = 1'b1;
                    end
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_clr) begin
            r_state <= S_IDLE;
            r_rem   <= '0;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_bcd   <= '0;
        end else begin
            r_state <= w_state_next;
            r_rem   <= w_rem_next;
            r_cnt   <= w_cnt_next;
            r_idx   <= w_idx_next;
            r_busy  <= w_busy_next;
            r_done  <= w_done_next;
            r_bcd   <= w_bcd_next;
        end
    end

`ifdef BIN2BCD_BLANK_EN
    logic [DIGITS-1:0] r_blank;
    logic [DIGITS-1:0] w_blank_calc;
    logic              w_zero_run;

    // Walk down from the MSD; a digit blanks only while everything above it is zero.
    always_comb begin
        w_blank_calc = '0;
        w_zero_run   = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            w_zero_run      = w_zero_run && (w_bcd_next[BCD_W*i +: BCD_W] == '0);
            w_blank_calc[i] = w_zero_run;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_clr) begin
            r_blank <= '0;
        end else if (w_done_next) begin
            r_blank <= w_blank_calc;
        end
    end

    assign o_blank = r_blank;
`else
    assign o_blank = '0;
`endif

    assign o_busy      = r_busy;
    assign o_done      = r_done;
    assign o_bcd       = r_bcd;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench for bin2bcd_seq: directed corner cases, exhaustive sweep
// and randomized back-to-back runs against a decimal-arithmetic reference.
module tb_bin2bcd_seq;

    localparam int WIDTH  = 8;
    localparam int DIGITS = 3;

    logic                  clk = 1'b0;
    logic                  i_clr;
    logic                  i_start;
    logic [WIDTH-1:0]      i_din;
    logic                  o_busy;
    logic                  o_done;
    logic [4*DIGITS-1:0]   o_bcd;
    logic [DIGITS-1:0]     o_blank;
    hex2bin_pkg::state_t   o_dbg_state;

    int n_checks = 0;
    int n_pass   = 0;
    logic [11:0] exp_q[$];

    always #5 clk = ~clk;

    bin2bcd_seq #(
        .WIDTH  (WIDTH),
        .DIGITS (DIGITS)
    ) dut (
        .i_clk       (clk),
        .i_clr       (i_clr),
        .i_start     (i_start),
        .i_din       (i_din),
        .o_busy      (o_busy),
        .o_done      (o_done),
        .o_bcd       (o_bcd),
        .o_blank     (o_blank),
        .o_dbg_state (o_dbg_state)
    );

    function automatic logic [11:0] ref_bcd(input int v);
        return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    function automatic int ref_lat(input int v);
        return v / 100 + (v / 10) % 10 + v % 10 + DIGITS;
    endfunction

    function automatic logic [2:0] ref_blank(input int v);
`ifdef BIN2BCD_BLANK_EN
        return {v < 100, v < 10, 1'b0};
`else
        return 3'b000;
`endif
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Counts edges until DONE is seen (bounded); scrambles DIN meanwhile.
    task automatic wait_done(output int n, output int busy_n);
        n = 0;
        busy_n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
            if (o_busy) busy_n++;
            if (!o_done) i_din = WIDTH'($urandom);
        end while (!o_done && n < 100);
        if (!o_done) check("done_timeout", 32'(o_done), 32'd1);
    endtask

    task automatic finish_conv(input int v, input int n, input int busy_n, input int pre);
        logic [11:0] e;
        check("latency", 32'(n + pre), 32'(ref_lat(v)));
        check("busy_cycles", 32'(busy_n + 1), 32'(ref_lat(v)));
        e = exp_q.pop_front();
        check("bcd", 32'(o_bcd), 32'(e));
        check("blank", 32'(o_blank), 32'(ref_blank(v)));
        check("busy_at_done", 32'(o_busy), 32'd0);
    endtask

    task automatic run_conv(input int v);
        int n, busy_n;
        @(negedge clk);
        i_din   = WIDTH'(v);
        i_start = 1'b1;
        exp_q.push_back(ref_bcd(v));
        @(posedge clk);
        #1;
        i_start = 1'b0;
        check("accept_busy", 32'(o_busy), 32'd1);
        check("accept_bcd_clr", 32'(o_bcd), 32'd0);
        wait_done(n, busy_n);
        finish_conv(v, n, busy_n, 0);
        @(posedge clk);
        #1;
        check("done_pulse", 32'(o_done), 32'd0);
        check("bcd_hold", 32'(o_bcd), 32'(ref_bcd(v)));
    endtask

    // START held in each DONE cycle, so conversions chain with no idle gap.
    task automatic run_b2b(input int vals[$]);
        int n, busy_n;
        @(negedge clk);
        i_din   = WIDTH'(vals[0]);
        i_start = 1'b1;
        @(posedge clk);
        #1;
        i_start = 1'b0;
        for (int k = 0; k < vals.size(); k++) begin
            exp_q.push_back(ref_bcd(vals[k]));
            wait_done(n, busy_n);
            finish_conv(vals[k], n, busy_n, 0);
            if (k + 1 < vals.size()) begin
                i_din   = WIDTH'(vals[k+1]);
                i_start = 1'b1;
                @(posedge clk);
                #1;
                i_start = 1'b0;
                check("b2b_no_gap", 32'(o_busy), 32'd1);
                check("b2b_bcd_clr", 32'(o_bcd), 32'd0);
            end
        end
    endtask

    initial begin
        int n, busy_n, dones;
        int rq[$];
        i_clr   = 1'b1;
        i_start = 1'b0;
        i_din   = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 32'(o_busy), 32'd0);
        check("rst_done", 32'(o_done), 32'd0);
        check("rst_bcd", 32'(o_bcd), 32'd0);
        check("rst_blank", 32'(o_blank), 32'd0);
        check("rst_state", 32'(o_dbg_state), 32'(hex2bin_pkg::S_IDLE));
        i_clr = 1'b0;

        run_conv(0);
        run_conv(255);

        // Second START while busy must be ignored.
        @(negedge clk);
        i_din   = 8'd100;
        i_start = 1'b1;
        exp_q.push_back(ref_bcd(100));
        @(posedge clk);
        #1;
        i_start = 1'b0;
        @(negedge clk);
        i_din   = 8'd55;
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        wait_done(n, busy_n);
        finish_conv(100, n, busy_n + 1, 1);
        dones = 0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk);
            #1;
            if (o_done) dones++;
        end
        check("ignored_start_dones", 32'(dones), 32'd0);
        check("ignored_start_bcd", 32'(o_bcd), 32'(ref_bcd(100)));

        rq = '{47, 9};
        run_b2b(rq);

        // CLR mid-conversion discards the partial result.
        @(negedge clk);
        i_din   = 8'd199;
        i_start = 1'b1;
        @(posedge clk);
        #1;
        i_start = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("pre_clr_busy", 32'(o_busy), 32'd1);
        i_clr = 1'b1;
        @(posedge clk);
        #1;
        i_clr = 1'b0;
        check("clr_busy", 32'(o_busy), 32'd0);
        check("clr_done", 32'(o_done), 32'd0);
        check("clr_bcd", 32'(o_bcd), 32'd0);
        check("clr_blank", 32'(o_blank), 32'd0);
        check("clr_state", 32'(o_dbg_state), 32'(hex2bin_pkg::S_IDLE));
        run_conv(7);

        for (int v = 0; v < 256; v++) run_conv(v);

        rq.delete();
        for (int k = 0; k < 24; k++) rq.push_back(int'($urandom_range(0, 255)));
        run_b2b(rq);

        check("exp_q_empty", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
